// File: rtl/picorv_axil_mem_slave.sv
// picorv_axil_mem_slave
//
// AXI4-Lite slave that terminates the PicoRV32 mem_axi_* master port with a
// word-organised, byte-strobed memory. Used as the bench and FPGA backing store
// for instruction fetch and load/store traffic.
//
// Ports:
//   clk, resetn           clock; synchronous active-low reset
//   mem_axi_aw*           write address channel (awprot ignored)
//   mem_axi_w*            write data channel with byte strobes
//   mem_axi_b*            write response channel (no bresp)
//   mem_axi_ar*           read address channel (arprot ignored)
//   mem_axi_r*            read data channel, data after READ_LATENCY cycles
//   oob_err               one-cycle pulse after any out-of-range access
//
// Optional feature: define AXIL_MEM_STALL_EN to compile in a 16-bit LFSR that
// randomly gates the three readies and defers the rising of bvalid/rvalid.

module picorv_axil_mem_slave #(
   parameter int unsigned MEM_WORDS    = 4096,
   parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,

   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,

   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,

   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,

   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata,

   output logic        oob_err
);

   localparam int unsigned IW = $clog2(MEM_WORDS);
   localparam logic [3:0] WAIT_INIT = (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

   logic [31:0] mem [MEM_WORDS];

   // Write buffers
   logic          aw_full;
   logic [IW-1:0] aw_idx;
   logic          aw_oob;
   logic          w_full;
   logic [31:0]   w_data;
   logic [3:0]    w_strb;

   // Read FSM state
   rstate_t rstate;
   logic [3:0] rcnt;

   logic stall;

   // Address decode; bit 32 of the offset is the borrow, i.e. addr < ADDR_BASE
   logic [32:0]   aw_off;
   logic [32:0]   ar_off;
   logic [IW-1:0] aw_idx_in;
   logic [IW-1:0] ar_idx_in;
   logic          aw_oob_in;
   logic          ar_oob_in;

   assign aw_off    = {1'b0, mem_axi_awaddr} - {1'b0, ADDR_BASE};
   assign ar_off    = {1'b0, mem_axi_araddr} - {1'b0, ADDR_BASE};
   assign aw_idx_in = aw_off[IW+1:2];
   assign ar_idx_in = ar_off[IW+1:2];
   assign aw_oob_in = aw_off[32] | ({3'b000, aw_off[31:2]} >= 33'(MEM_WORDS));
   assign ar_oob_in = ar_off[32] | ({3'b000, ar_off[31:2]} >= 33'(MEM_WORDS));

`ifdef AXIL_MEM_STALL_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11 (right-shift form)
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr <= STALL_SEED;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end

   assign stall = lfsr[0];

   logic unused;
   assign unused = ^{mem_axi_awprot, mem_axi_arprot, aw_off[1:0], ar_off[1:0]};
`else
   assign stall = 1'b0;

   logic unused;
   assign unused = ^{mem_axi_awprot, mem_axi_arprot, aw_off[1:0], ar_off[1:0], STALL_SEED};
`endif

   // Readies are gated by resetn so they read 0 throughout reset and 1 in the
   // first cycle after release.
   assign mem_axi_awready = resetn & ~aw_full & ~stall;
   assign mem_axi_wready  = resetn & ~w_full & ~stall;
   assign mem_axi_arready = resetn & (rstate == R_IDLE) & ~stall;

   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   assign aw_hs = mem_axi_awvalid & mem_axi_awready;
   assign w_hs  = mem_axi_wvalid & mem_axi_wready;
   assign ar_hs = mem_axi_arvalid & mem_axi_arready;

   // Commit sees a handshake on the same edge as if it were already buffered
   logic          commit;
   logic [IW-1:0] cur_aw_idx;
   logic          cur_aw_oob;
   logic [31:0]   cur_wdata;
   logic [3:0]    cur_wstrb;

   assign cur_aw_idx = aw_full ? aw_idx : aw_idx_in;
   assign cur_aw_oob = aw_full ? aw_oob : aw_oob_in;
   assign cur_wdata  = w_full ? w_data : mem_axi_wdata;
   assign cur_wstrb  = w_full ? w_strb : mem_axi_wstrb;
   assign commit     = resetn & (aw_full | aw_hs) & (w_full | w_hs)
                     & (~mem_axi_bvalid | mem_axi_bready) & ~stall;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         aw_full        <= 1'b0;
         w_full         <= 1'b0;
         mem_axi_bvalid <= 1'b0;
         oob_err        <= 1'b0;
      end else begin
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
         end else begin
            if (aw_hs) aw_full <= 1'b1;
            if (w_hs)  w_full  <= 1'b1;
         end
         if (commit) begin
            mem_axi_bvalid <= 1'b1;
         end else if (mem_axi_bready) begin
            mem_axi_bvalid <= 1'b0;
         end
         oob_err <= (commit & cur_aw_oob) | (ar_hs & ar_oob_in);
      end
   end

   // Buffer payloads need no reset; the full flags qualify them
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         aw_idx <= aw_idx_in;
         aw_oob <= aw_oob_in;
      end
      if (w_hs) begin
         w_data <= mem_axi_wdata;
         w_strb <= mem_axi_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && !cur_aw_oob) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_wstrb[i]) mem[cur_aw_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

   // Write-first read: merge bytes being committed on the same edge
   logic [31:0] rd_word;
   always_comb begin
      rd_word = mem[ar_idx_in];
      for (int i = 0; i < 4; i++) begin
         if (commit && !cur_aw_oob && (cur_aw_idx == ar_idx_in) && cur_wstrb[i]) begin
            rd_word[8*i +: 8] = cur_wdata[8*i +: 8];
         end
      end
      if (ar_oob_in) rd_word = 32'hDEADBEEF;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rstate         <= R_IDLE;
         rcnt           <= 4'd0;
         mem_axi_rvalid <= 1'b0;
         mem_axi_rdata  <= 32'h0;
      end else begin
         unique case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  mem_axi_rdata <= rd_word;
                  if (READ_LATENCY <= 1) begin
                     rstate         <= R_RESP;
                     mem_axi_rvalid <= 1'b1;
                  end else begin
                     rstate <= R_WAIT;
                     rcnt   <= WAIT_INIT;
                  end
               end
            end
            R_WAIT: begin
               if (rcnt != 4'd0) begin
                  rcnt <= rcnt - 4'd1;
               end else if (!stall) begin
                  rstate         <= R_RESP;
                  mem_axi_rvalid <= 1'b1;
               end
            end
            R_RESP: begin
               if (mem_axi_rready) begin
                  rstate         <= R_IDLE;
                  mem_axi_rvalid <= 1'b0;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_picorv_axil_mem_slave.sv
// Self-checking bench for picorv_axil_mem_slave: reset, directed vector table,
// hand-written backpressure/reset sequences and a randomized scoreboard run.

module tb_picorv_axil_mem_slave;

   localparam int unsigned MEM_WORDS = 64;
   localparam logic [31:0] B         = 32'h0000_1000;
   localparam int unsigned LAT       = 3;
   localparam logic [31:0] OOBA      = B + MEM_WORDS * 4;
   localparam int          MAXW      = 100;
   localparam int          NRAND     = 1000;

   logic        clk;
   logic        resetn;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, oob_err;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;

   picorv_axil_mem_slave #(
      .MEM_WORDS   (MEM_WORDS),
      .ADDR_BASE   (B),
      .READ_LATENCY(LAT),
      .STALL_SEED  (16'hACE1)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .mem_axi_awvalid(awvalid),
      .mem_axi_awready(awready),
      .mem_axi_awaddr (awaddr),
      .mem_axi_awprot (awprot),
      .mem_axi_wvalid (wvalid),
      .mem_axi_wready (wready),
      .mem_axi_wdata  (wdata),
      .mem_axi_wstrb  (wstrb),
      .mem_axi_bvalid (bvalid),
      .mem_axi_bready (bready),
      .mem_axi_arvalid(arvalid),
      .mem_axi_arready(arready),
      .mem_axi_araddr (araddr),
      .mem_axi_arprot (arprot),
      .mem_axi_rvalid (rvalid),
      .mem_axi_rready (rready),
      .mem_axi_rdata  (rdata),
      .oob_err        (oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int aw_gate  = 0;
   int w_gate   = 0;
   int ar_gate  = 0;
   int b_drop   = 0;
   int r_drop   = 0;

   logic [31:0] model_mem [MEM_WORDS];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic check_blat(input string name, input int blat);
`ifdef AXIL_MEM_STALL_EN
      check1(name, blat >= 1 && blat <= MAXW, 1'b1);
`else
      check32(name, 32'(blat), 32'd1);
`endif
   endtask

   task automatic check_rlat(input string name, input int rlat);
`ifdef AXIL_MEM_STALL_EN
      check1(name, rlat >= int'(LAT) && rlat <= MAXW, 1'b1);
`else
      check32(name, 32'(rlat), 32'(LAT));
`endif
   endtask

   function automatic bit model_oob(input logic [31:0] a);
      longint off;
      off = longint'({32'b0, a}) - longint'({32'b0, B});
      return (off < 0) || (off / 4 >= longint'(MEM_WORDS));
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((longint'({32'b0, a}) - longint'({32'b0, B})) / 4);
   endfunction

   // Reference write: byte lanes with strobe set replace the stored word's bytes
   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      if (!model_oob(a)) begin
         idx = model_idx(a);
         for (int i = 0; i < 4; i++) if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (model_oob(a)) return 32'hDEADBEEF;
      return model_mem[model_idx(a)];
   endfunction

   // All tasks start and end at posedge+1 with every valid/ready input low
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output int blat, output bit oob_seen);
      int cyc;
      int bw;
      bit awd, wd, hs_aw, hs_w;
      awd = 0; wd = 0; cyc = 0;
      awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
      while (!(awd && wd) && cyc < MAXW) begin
         awvalid = !awd && cyc >= aw_dly;
         wvalid  = !wd && cyc >= w_dly;
         @(negedge clk);
         if (!awd && !awready) aw_gate++;
         if (!wd && !wready) w_gate++;
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         @(posedge clk); #1;
         awd |= hs_aw;
         wd  |= hs_w;
         cyc++;
      end
      awvalid = 0; wvalid = 0;
      check32("wr_accept", {30'b0, awd, wd}, 32'd3);
      bw = 0;
      while (!bvalid && bw < MAXW) begin
         @(posedge clk); #1;
         bw++;
      end
      blat = bw + 1;
      oob_seen = oob_err;
      for (int i = 0; i < b_dly; i++) begin
         @(posedge clk); #1;
         if (!bvalid) b_drop++;
      end
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output int rlat, output bit oob_seen);
      int cyc;
      int rw;
      bit ard, hs;
      ard = 0; cyc = 0;
      araddr = a; arprot = 3'($urandom);
      while (!ard && cyc < MAXW) begin
         arvalid = cyc >= ar_dly;
         @(negedge clk);
         if (!arready) ar_gate++;
         hs = arvalid && arready;
         @(posedge clk); #1;
         ard = hs;
         cyc++;
      end
      arvalid = 0;
      check1("rd_accept", ard, 1'b1);
      oob_seen = oob_err;
      rw = 0;
      while (!rvalid && rw < MAXW) begin
         @(posedge clk); #1;
         rw++;
      end
      rlat = rw + 1;
      data = rdata;
      for (int i = 0; i < r_dly; i++) begin
         @(posedge clk); #1;
         if (!rvalid || rdata !== data) r_drop++;
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      bit          exp_oob;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int          blat, rlat, bad, cyc, op;
      bit          oob;
      logic [31:0] d, a, d0;
      logic [3:0]  s;

      resetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;

      // Reset: everything low for all 5 reset cycles
      bad = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         if (awready || wready || arready || bvalid || rvalid || oob_err || rdata !== 32'h0)
            bad++;
         if (i < 4) begin @(posedge clk); #1; end
      end
      check32("reset_outputs_low", 32'(bad), 32'd0);
      check32("reset_rdata", rdata, 32'h0);
      resetn = 1;
      #1;
`ifndef AXIL_MEM_STALL_EN
      check1("first_cycle_awready", awready, 1'b1);
      check1("first_cycle_wready", wready, 1'b1);
      check1("first_cycle_arready", arready, 1'b1);
`endif
      @(posedge clk); #1;

      // AW then W three cycles later, then a read at LAT=3
      axi_write(B + 32'h10, 32'hA5A51234, 4'hF, 0, 3, 0, blat, oob);
      check_blat("aw_then_w_blat", blat);
      axi_read(B + 32'h10, 0, 0, d, rlat, oob);
      check_rlat("aw_then_w_rlat", rlat);
      check32("aw_then_w_rdata", d, 32'hA5A51234);

      vecs[0]  = '{1, B + 32'h20, 32'h11223344, 4'hF, 32'h0, 0};
      vecs[1]  = '{1, B + 32'h20, 32'hFFFFFFFF, 4'b0101, 32'h0, 0};
      vecs[2]  = '{0, B + 32'h20, 32'h0, 4'h0, 32'h11FF33FF, 0};
      vecs[3]  = '{1, B, 32'h0BADF00D, 4'hF, 32'h0, 0};
      vecs[4]  = '{1, OOBA, 32'h55555555, 4'hF, 32'h0, 1};
      vecs[5]  = '{0, B, 32'h0, 4'h0, 32'h0BADF00D, 0};
      vecs[6]  = '{0, OOBA, 32'h0, 4'h0, 32'hDEADBEEF, 1};
      vecs[7]  = '{1, B + 32'hFC, 32'h01020304, 4'hF, 32'h0, 0};
      vecs[8]  = '{1, B + 32'hFF, 32'hCAFEBABE, 4'b1010, 32'h0, 0};
      vecs[9]  = '{1, B - 32'h4, 32'h66666666, 4'hF, 32'h0, 1};
      vecs[10] = '{0, B + 32'hFE, 32'h0, 4'h0, 32'hCA02BA04, 0};
      vecs[11] = '{0, B - 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 1};
      vecs[12] = '{1, B + 32'h24, 32'hAABBCCDD, 4'hF, 32'h0, 0};
      vecs[13] = '{1, B + 32'h24, 32'h12345678, 4'h0, 32'h0, 0};
      vecs[14] = '{0, B + 32'h24, 32'h0, 4'h0, 32'hAABBCCDD, 0};

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, blat, oob);
            check_blat($sformatf("vec%0d_blat", i), blat);
            check1($sformatf("vec%0d_wr_oob", i), oob, vecs[i].exp_oob);
            check1($sformatf("vec%0d_oob_clear", i), oob_err, 1'b0);
         end else begin
            axi_read(vecs[i].addr, 0, 0, d, rlat, oob);
            check_rlat($sformatf("vec%0d_rlat", i), rlat);
            check1($sformatf("vec%0d_rd_oob", i), oob, vecs[i].exp_oob);
            check32($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
         end
      end

`ifndef AXIL_MEM_STALL_EN
      // oob_err for a read is a single-cycle pulse after the AR edge
      araddr = OOBA; arvalid = 1;
      @(posedge clk); #1;
      arvalid = 0;
      check1("oob_pulse_high", oob_err, 1'b1);
      @(posedge clk); #1;
      check1("oob_pulse_low", oob_err, 1'b0);
      cyc = 0;
      while (!rvalid && cyc < MAXW) begin @(posedge clk); #1; cyc++; end
      check32("oob_pulse_rdata", rdata, 32'hDEADBEEF);
      rready = 1; @(posedge clk); #1; rready = 0;

      // B backpressure: three writes queued behind a stalled response
      bready = 0;
      awaddr = B + 32'h30; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(posedge clk); #1;
      check1("bp_first_bvalid", bvalid, 1'b1);
      awaddr = B + 32'h34; wdata = 32'h22222222;
      @(posedge clk); #1;
      check1("bp_second_buffered", awready | wready, 1'b0);
      awaddr = B + 32'h38; wdata = 32'h33333333;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!bvalid || awready || wready) bad++;
      end
      check32("bp_hold", 32'(bad), 32'd0);
      bready = 1;
      @(posedge clk); #1;
      check1("bp_second_bvalid", bvalid, 1'b1);
      check1("bp_awready_back", awready, 1'b1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      check1("bp_third_bvalid", bvalid, 1'b1);
      @(posedge clk); #1;
      bready = 0;
      check1("bp_drained", bvalid, 1'b0);
      axi_read(B + 32'h30, 0, 0, d, rlat, oob);
      check32("bp_rd1", d, 32'h11111111);
      axi_read(B + 32'h34, 0, 0, d, rlat, oob);
      check32("bp_rd2", d, 32'h22222222);
      axi_read(B + 32'h38, 0, 0, d, rlat, oob);
      check32("bp_rd3", d, 32'h33333333);

      // R backpressure: rdata stable, no new AR accepted
      araddr = B + 32'h20; arvalid = 1;
      @(posedge clk); #1;
      araddr = B + 32'h24;
      cyc = 0;
      while (!rvalid && cyc < MAXW) begin @(posedge clk); #1; cyc++; end
      d0 = rdata;
      check32("rbp_rdata", d0, 32'h11FF33FF);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (!rvalid || rdata !== d0 || arready) bad++;
      end
      check32("rbp_hold", 32'(bad), 32'd0);
      arvalid = 0; rready = 1;
      @(posedge clk); #1;
      rready = 0;
      check1("rbp_rvalid_drop", rvalid, 1'b0);
      check1("rbp_arready_back", arready, 1'b1);

      // Reset mid-operation discards buffered AW and an in-flight read
      axi_write(B + 32'h28, 32'h13579BDF, 4'hF, 0, 0, 0, blat, oob);
      awaddr = B + 32'h28; awvalid = 1;
      @(posedge clk); #1;
      awvalid = 0;
      check1("mrst_aw_buffered", awready, 1'b0);
      araddr = B + 32'h28; arvalid = 1;
      @(posedge clk); #1;
      arvalid = 0;
      resetn = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1;
      #1;
      check1("mrst_aw_cleared", awready, 1'b1);
      wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
      @(posedge clk); #1;
      wvalid = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bvalid || rvalid) bad++;
      end
      check32("mrst_no_responses", 32'(bad), 32'd0);
      resetn = 0;
      @(posedge clk); #1;
      resetn = 1;
      @(posedge clk); #1;
      axi_read(B + 32'h28, 0, 0, d, rlat, oob);
      check32("mrst_mem_intact", d, 32'h13579BDF);
`endif

      // Randomized run against the reference model
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         d = $urandom;
         axi_write(B + 32'(i * 4), d, 4'hF, 0, 0, 0, blat, oob);
         model_mem[i] = d;
      end
      for (int n = 0; n < NRAND; n++) begin
         op = $urandom_range(0, 99);
         if (op < 80) a = B + 32'($urandom_range(0, MEM_WORDS * 4 - 1));
         else if (op < 90) a = OOBA + 32'($urandom_range(0, 255));
         else a = B - 32'($urandom_range(1, 255));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom);
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), blat, oob);
            model_write(a, d, s);
            check_blat("rand_blat", blat);
            check1("rand_wr_oob", oob, model_oob(a));
         end else begin
            axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, rlat, oob);
            check_rlat("rand_rlat", rlat);
            check1("rand_rd_oob", oob, model_oob(a));
            check32("rand_rdata", d, model_read(a));
         end
      end

      check32("b_held_until_ready", 32'(b_drop), 32'd0);
      check32("r_held_until_ready", 32'(r_drop), 32'd0);
`ifdef AXIL_MEM_STALL_EN
      check1("aw_gating_seen", aw_gate > 0, 1'b1);
      check1("w_gating_seen", w_gate > 0, 1'b1);
      check1("ar_gating_seen", ar_gate > 0, 1'b1);
`else
      check32("aw_never_gated", 32'(aw_gate), 32'd0);
      check32("w_never_gated", 32'(w_gate), 32'd0);
      check32("ar_never_gated", 32'(ar_gate), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               n_pass, n_checks);
      $fatal(1);
   end

endmodule
